// File: rtl/fetch_stage.sv
// Instruction fetch stage: walks the PC through a combinational instruction memory
// and assembles one- and two-word instructions into the IF/ID register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        jump_taken,
    input  logic [15:0] jump_target,
    output logic [15:0] instruction_buf,
    output logic [15:0] immediate_buf,
    output logic [15:0] pc_buf,
    output logic        instr_valid
);

    typedef enum logic {
        FETCH = 1'b0,
        IMM   = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc, pc_next;
    logic [15:0] hold_reg, hold_reg_next;
    logic [15:0] hold_pc, hold_pc_next;
    logic [15:0] instr_next, imm_next, pc_buf_next;
    logic        valid_next;
    logic        two_word;

    assign imem_addr = pc;
    assign two_word  = (imem_data[15:14] == 2'b11);

    always_comb begin
        // NOTE: every next value defaults to its current value, so no path leaves
        // one unassigned (no latch) and a stall is simply "take the defaults".
        state_next    = state;
        pc_next       = pc;
        hold_reg_next = hold_reg;
        hold_pc_next  = hold_pc;
        instr_next    = instruction_buf;
        imm_next      = immediate_buf;
        pc_buf_next   = pc_buf;
        valid_next    = instr_valid;

        if (jump_taken) begin
            // A redirect squashes whatever was in flight, including a pending IMM word.
            state_next = FETCH;
            pc_next    = jump_target;
            instr_next = NOP_WORD;
            imm_next   = 16'h0000;
            valid_next = 1'b0;
        end else if (!stall) begin
            pc_next = pc + 16'd1;
            case (state)
                FETCH: begin
                    if (two_word) begin
                        hold_reg_next = imem_data;
                        hold_pc_next  = pc;
                        instr_next    = NOP_WORD;
                        imm_next      = 16'h0000;
                        valid_next    = 1'b0;
                        state_next    = IMM;
                    end else begin
                        instr_next  = imem_data;
                        imm_next    = 16'h0000;
                        pc_buf_next = pc;
                        valid_next  = 1'b1;
                    end
                end
                IMM: begin
                    // The second word is raw immediate data; its top bits mean nothing here.
                    instr_next  = hold_reg;
                    imm_next    = imem_data;
                    pc_buf_next = hold_pc;
                    valid_next  = 1'b1;
                    state_next  = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values computed above, independent of statement order.
        if (reset) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            hold_reg        <= 16'h0000;
            hold_pc         <= 16'h0000;
            instruction_buf <= NOP_WORD;
            immediate_buf   <= 16'h0000;
            pc_buf          <= RESET_PC;
            instr_valid     <= 1'b0;
        end else begin
            state           <= state_next;
            pc              <= pc_next;
            hold_reg        <= hold_reg_next;
            hold_pc         <= hold_pc_next;
            instruction_buf <= instr_next;
            immediate_buf   <= imm_next;
            pc_buf          <= pc_buf_next;
            instr_valid     <= valid_next;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Parameter: NOP_WORD, 16'h0000, instruction word driven on bubbles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  16  word address to instruction memory; equals current PC register.
REQ-006 imem_data  input  16  instruction memory word at imem_addr, combinational, same cycle.
REQ-007 stall  input  1  hold all fetch state and outputs this cycle.
REQ-008 jump_taken  input  1  redirect PC to jump_target, squash in-flight fetch.
REQ-009 jump_target  input  16  redirect address, sampled when jump_taken=1.
REQ-010 instruction_buf  output  16  IF/ID register: instruction word fed to decode.
REQ-011 immediate_buf  output  16  IF/ID register: second word of a two-word instruction, else 0.
REQ-012 pc_buf  output  16  address of first word of instruction in instruction_buf.
REQ-013 instr_valid  output  1  1 when instruction_buf holds a real instruction, 0 on bubble.

Function
REQ-014 Two-word instruction SHALL be detected as imem_data[15:14]==2'b11 (opcode[4:3]==2'b11); all others are single-word.
REQ-015 FSM states SHALL be FETCH and IMM; reset state FETCH.
REQ-016 FETCH, single-word: instruction_buf<=imem_data, immediate_buf<=0, pc_buf<=PC, instr_valid<=1, PC<=PC+1, stay FETCH.
REQ-017 FETCH, two-word: hold_reg<=imem_data, hold_pc<=PC, PC<=PC+1, instruction_buf<=NOP_WORD, immediate_buf<=0, instr_valid<=0, go IMM.
REQ-018 IMM: instruction_buf<=hold_reg, immediate_buf<=imem_data (no opcode decode of this word), pc_buf<=hold_pc, instr_valid<=1, PC<=PC+1, go FETCH.
REQ-019 Two-word instruction SHALL therefore reach decode one bubble cycle later than a single-word one; latency PC-present to instruction_buf = 1 cycle (single), 2 cycles (two-word).
REQ-020 PC arithmetic SHALL be 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000, including an immediate word fetched across the wrap.
REQ-021 stall=1, jump_taken=0: PC, state, hold_reg, hold_pc and all outputs SHALL keep their values.
REQ-022 jump_taken=1: PC<=jump_target, state<=FETCH, instruction_buf<=NOP_WORD, immediate_buf<=0, instr_valid<=0; pc_buf holds; any pending IMM word is discarded.
REQ-023 Priority SHALL be reset > jump_taken > stall > normal fetch; jump_taken wins over simultaneous stall.
REQ-024 jump_taken in IMM state SHALL abandon the half-fetched instruction; it never appears with instr_valid=1.
REQ-025 imem_addr SHALL equal PC combinationally in every cycle, including stall and reset cycles.
REQ-026 No output SHALL be X after the first reset edge, regardless of imem_data content.

Reset
REQ-027 On a rising edge with reset=1: PC<=RESET_PC, state<=FETCH, instruction_buf<=NOP_WORD, immediate_buf<=0, pc_buf<=RESET_PC, instr_valid<=0, hold_reg<=0, hold_pc<=0.
REQ-028 reset mid-IMM or mid-stall SHALL discard pending state; first fetch after reset deassert is from RESET_PC.
REQ-029 reset overrides jump_taken and stall in the same cycle.

Verification
REQ-030 Reset then imem words M[0]=16'h0A20, M[1]=16'h1100 -> cycle1 instruction_buf=0A20 pc_buf=0000 valid=1; cycle2 instruction_buf=1100 pc_buf=0001 valid=1.
REQ-031 M[2]=16'hC300 (two-word), M[3]=16'h00FF -> bubble (valid=0, NOP) then instruction_buf=C300 immediate_buf=00FF pc_buf=0002 valid=1; PC=0004.
REQ-032 stall=1 for 3 cycles at PC=0005 -> imem_addr stays 0005, outputs unchanged; release -> normal fetch resumes at 0005.
REQ-033 jump_taken=1, jump_target=16'h0040 while in IMM state -> next cycle PC=0040, valid=0, state FETCH; discarded instruction never output valid.
REQ-034 jump_taken=1 with stall=1 simultaneously, target 16'h0100 -> PC=0100, valid=0 (jump wins).
REQ-035 PC=16'hFFFF holding two-word word 16'hD000, M[0000]=16'h1234 -> instruction_buf=D000 immediate_buf=1234 pc_buf=FFFF; PC=0001.
